// File: rtl/aes_fetch_controller.sv
// AES fetch controller: walks cyphertext/key memory and hands blocks to the core.
// Define FETCH_LOOP_EN to restart the run at address 0 after every pass.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef TEXT_WIDTH
`define TEXT_WIDTH 128
`endif
`ifndef KEY_WIDTH
`define KEY_WIDTH 128
`endif
`ifndef MEMORY_SIZE
`define MEMORY_SIZE 16
`endif

module aes_fetch_controller (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [`ADDR_WIDTH:0]   num_blocks_i,
  output logic [`ADDR_WIDTH-1:0] pc_o,
  input  logic [`TEXT_WIDTH-1:0] cyphertext_i,
  input  logic [`KEY_WIDTH-1:0]  key_i,
  output logic [`TEXT_WIDTH-1:0] text_o,
  output logic [`KEY_WIDTH-1:0]  key_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [`ADDR_WIDTH:0]   block_cnt_o
);

  localparam int AW = `ADDR_WIDTH;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MEM_SIZE = CW'(`MEMORY_SIZE);
`ifdef FETCH_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] num_sat;
  logic          do_start;
  logic          do_cap;
  logic          do_hs;
  logic          last;

  assign num_sat = (num_blocks_i > MEM_SIZE) ? MEM_SIZE : num_blocks_i;

  // Every action below is gated by !abort_i so abort wins outright.
  assign do_start = !abort_i && state_q == IDLE &&
                    start_i && num_blocks_i != '0;
  assign do_cap   = !abort_i && state_q == FETCH;
  assign do_hs    = !abort_i && state_q == HOLD &&
                    valid_o && ready_i;
  assign last     = {1'b0, pc_o} == cnt_q - CW'(1);

  assign busy_o = state_q == FETCH || state_q == HOLD;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (do_start) state_d = FETCH;
      end
      FETCH: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (do_hs) begin
          if (!last)     state_d = FETCH;
          else if (LOOP) state_d = FETCH;
          else           state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_o        <= '0;
      text_o      <= '0;
      key_o       <= '0;
      valid_o     <= 1'b0;
      done_o      <= 1'b0;
      block_cnt_o <= '0;
      cnt_q       <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (1'b1)
        abort_i: begin
          pc_o        <= '0;
          valid_o     <= 1'b0;
          block_cnt_o <= '0;
        end
        do_start: begin
          cnt_q       <= num_sat;
          pc_o        <= '0;
          block_cnt_o <= '0;
        end
        do_cap: begin
          text_o  <= cyphertext_i;
          key_o   <= key_i;
          valid_o <= 1'b1;
        end
        do_hs: begin
          valid_o     <= 1'b0;
          block_cnt_o <= block_cnt_o + CW'(1);
          if (!last) begin
            pc_o <= pc_o + AW'(1);
          end else begin
            done_o <= 1'b1;
            if (LOOP) begin
              pc_o        <= '0;
              block_cnt_o <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_fetch_controller.sv
// Bench for aes_fetch_controller: vector table, cycle-exact sequences,
// and a block scoreboard fed from a negedge-read memory model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef TEXT_WIDTH
`define TEXT_WIDTH 128
`endif
`ifndef KEY_WIDTH
`define KEY_WIDTH 128
`endif
`ifndef MEMORY_SIZE
`define MEMORY_SIZE 16
`endif

module tb_aes_fetch_controller;

  localparam int AW = `ADDR_WIDTH;
  localparam int MS = `MEMORY_SIZE;

  logic                   clk_i = 1'b0;
  logic                   rst_n_i;
  logic                   start_i;
  logic                   abort_i;
  logic [AW:0]            num_blocks_i;
  logic [AW-1:0]          pc_o;
  logic [`TEXT_WIDTH-1:0] cyphertext_i;
  logic [`KEY_WIDTH-1:0]  key_i;
  logic [`TEXT_WIDTH-1:0] text_o;
  logic [`KEY_WIDTH-1:0]  key_o;
  logic                   valid_o;
  logic                   ready_i;
  logic                   busy_o;
  logic                   done_o;
  logic [AW:0]            block_cnt_o;

  aes_fetch_controller dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .num_blocks_i (num_blocks_i),
    .pc_o         (pc_o),
    .cyphertext_i (cyphertext_i),
    .key_i        (key_i),
    .text_o       (text_o),
    .key_o        (key_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .block_cnt_o  (block_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  logic [`TEXT_WIDTH-1:0] mem_text [MS];
  logic [`KEY_WIDTH-1:0]  mem_key  [MS];

  always @(negedge clk_i) begin
    cyphertext_i <= mem_text[pc_o];
    key_i        <= mem_key[pc_o];
  end

  typedef struct {
    logic [AW-1:0]          pc;
    logic [`TEXT_WIDTH-1:0] text;
    logic [`KEY_WIDTH-1:0]  key;
  } blk_t;

  blk_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_run(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      blk_t b;
      b.pc   = AW'(first + i);
      b.text = mem_text[first + i];
      b.key  = mem_key[first + i];
      sb.push_back(b);
    end
  endtask

  // Handshake happens at the coming posedge; compare against the queue head.
  always @(negedge clk_i) begin
    if (rst_n_i === 1'b1 && valid_o === 1'b1 &&
        ready_i === 1'b1 && abort_i === 1'b0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_block", 1, 0);
      end else begin
        blk_t b;
        b = sb.pop_front();
        chk("sb_pc", pc_o, b.pc);
        chk("sb_text", text_o, b.text);
        chk("sb_key", key_o, b.key);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic launch(input int nb);
    start_i      = 1'b1;
    num_blocks_i = (AW+1)'(nb);
    tick();
    start_i = 1'b0;
  endtask

  typedef struct {
    int nb;
    int blocks;
    int last_pc;
  } vec_t;

  vec_t tbl[4];

  initial begin
    rst_n_i      = 1'b0;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    ready_i      = 1'b0;
    num_blocks_i = '0;
    for (int i = 0; i < MS; i++) begin
      mem_text[i] = {$urandom, $urandom, $urandom, $urandom};
      mem_key[i]  = {$urandom, $urandom, $urandom, $urandom};
    end

    #3;
    chk("rst_pc", pc_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_cnt", block_cnt_o, 0);
    chk("rst_text", text_o, 0);
    chk("rst_key", key_o, 0);
    #14;
    rst_n_i = 1'b1;
    tick();

    // abort beats start in IDLE
    start_i      = 1'b1;
    abort_i      = 1'b1;
    num_blocks_i = 3;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("abort_start_busy", busy_o, 0);
    tick();
    chk("abort_start_busy2", busy_o, 0);

`ifndef FETCH_LOOP_EN
    tbl[0] = '{nb: 3,      blocks: 3,  last_pc: 2};
    tbl[1] = '{nb: 1,      blocks: 1,  last_pc: 0};
    tbl[2] = '{nb: 0,      blocks: 0,  last_pc: 0};
    tbl[3] = '{nb: MS + 5, blocks: MS, last_pc: MS - 1};

    ready_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      push_run(0, tbl[t].blocks);
      launch(tbl[t].nb);
      if (tbl[t].blocks == 0) begin
        for (int c = 1; c <= 3; c++) begin
          chk("zero_busy", busy_o, 0);
          chk("zero_valid", valid_o, 0);
          tick();
        end
      end else begin
        for (int c = 1; c <= 2 * tbl[t].blocks; c++) begin
          chk("run_busy", busy_o, 1);
          chk("run_done", done_o, 0);
          chk("run_valid", valid_o, (c % 2 == 0) ? 1 : 0);
          if (c % 2 == 0) chk("run_pc", pc_o, c / 2 - 1);
          tick();
        end
        chk("end_done", done_o, 1);
        chk("end_busy", busy_o, 0);
        chk("end_cnt", block_cnt_o, tbl[t].blocks);
        chk("end_pc", pc_o, tbl[t].last_pc);
        tick();
        chk("idle_done", done_o, 0);
        chk("idle_pc", pc_o, tbl[t].last_pc);
        chk("idle_cnt", block_cnt_o, tbl[t].blocks);
      end
      chk("sb_empty", sb.size(), 0);
      tick();
    end

    // back-pressure on the first block
    ready_i = 1'b0;
    push_run(0, 2);
    launch(2);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", valid_o, 1);
      chk("stall_text", text_o, mem_text[0]);
      chk("stall_cnt", block_cnt_o, 0);
      tick();
    end
    ready_i = 1'b1;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        if (done_o) seen = 1'b1;
      end
      chk("stall_done_seen", seen, 1);
    end
    chk("stall_cnt_end", block_cnt_o, 2);
    chk("stall_sb_empty", sb.size(), 0);
    tick();
`else
    // looping pass of two blocks, three passes
    ready_i = 1'b1;
    push_run(0, 2);
    push_run(0, 2);
    push_run(0, 2);
    launch(2);
    for (int c = 1; c <= 12; c++) begin
      chk("loop_busy", busy_o, 1);
      chk("loop_done", done_o, (c > 1 && c % 4 == 1) ? 1 : 0);
      chk("loop_valid", valid_o, (c % 2 == 0) ? 1 : 0);
      if (c % 2 == 0) chk("loop_pc", pc_o, (c / 2 - 1) % 2);
      if (c % 4 == 1 && c > 1) chk("loop_cnt", block_cnt_o, 0);
      tick();
    end
    chk("loop_done13", done_o, 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("loop_abort_busy", busy_o, 0);
    chk("loop_abort_valid", valid_o, 0);
    chk("loop_abort_pc", pc_o, 0);
    tick();
    chk("loop_abort_done", done_o, 0);
    chk("loop_abort_busy2", busy_o, 0);
    chk("loop_sb_empty", sb.size(), 0);
`endif

    // abort together with ready while holding block 1
    ready_i = 1'b1;
    push_run(0, 1);
    launch(3);
    tick();
    tick();
    tick();
    chk("ab_valid_pre", valid_o, 1);
    chk("ab_pc_pre", pc_o, 1);
    chk("ab_cnt_pre", block_cnt_o, 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("ab_valid", valid_o, 0);
    chk("ab_cnt", block_cnt_o, 0);
    chk("ab_pc", pc_o, 0);
    chk("ab_busy", busy_o, 0);
    chk("ab_done", done_o, 0);
    tick();
    chk("ab_done2", done_o, 0);
    chk("ab_busy2", busy_o, 0);
    chk("ab_sb_empty", sb.size(), 0);

    // reset while holding block 2
    push_run(0, 2);
    launch(3);
    for (int c = 1; c < 6; c++) tick();
    chk("rh_valid_pre", valid_o, 1);
    chk("rh_pc_pre", pc_o, 2);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("rh_pc", pc_o, 0);
    chk("rh_valid", valid_o, 0);
    chk("rh_busy", busy_o, 0);
    chk("rh_done", done_o, 0);
    chk("rh_cnt", block_cnt_o, 0);
    chk("rh_text", text_o, 0);
    chk("rh_key", key_o, 0);
    sb.delete();
    tick();
    #3;
    rst_n_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rh_after_busy", busy_o, 0);
      chk("rh_after_done", done_o, 0);
      chk("rh_after_valid", valid_o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
